// File: rtl/mac_accel_arbiter.sv
// Purpose : shares one MAC accelerator OBI subordinate between two OBI managers, with round-robin arbitration and a software lock register at LockOffset.
// Latency : forwarded gnt/rvalid pass through combinationally; lock-register accesses get gnt in cycle N and rvalid in cycle N+1.
// Backpress: one transaction outstanding; a non-owner of a held lock sees gnt=0 until release. Optional stale-lock watchdog: MAC_ARB_LOCK_TIMEOUT_EN.

package mac_arb_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } sbr_obi_a_t;

    typedef struct packed {
        logic       req;
        sbr_obi_a_t a;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } sbr_obi_r_t;

    typedef struct packed {
        logic       gnt;
        logic       rvalid;
        sbr_obi_r_t r;
    } sbr_obi_rsp_t;

endpackage

module mac_accel_arbiter #(
    parameter mac_arb_pkg::obi_cfg_t ObiCfg      = mac_arb_pkg::SbrObiCfg,
    parameter type                   obi_req_t   = mac_arb_pkg::sbr_obi_req_t,
    parameter type                   obi_rsp_t   = mac_arb_pkg::sbr_obi_rsp_t,
    parameter logic [7:0]            LockOffset  = 8'hFC,
    parameter int unsigned           LockTimeout = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  obi_req_t   sbr0_obi_req_i,
    output obi_rsp_t   sbr0_obi_rsp_o,
    input  obi_req_t   sbr1_obi_req_i,
    output obi_rsp_t   sbr1_obi_rsp_o,
    output obi_req_t   mgr_obi_req_o,
    input  obi_rsp_t   mgr_obi_rsp_i,
    output logic [1:0] lock_owner_o,
    output logic       lock_timeout_o
);

    if (LockTimeout < 2) begin : g_timeout_chk
        $error("LockTimeout must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FWD_WAIT  = 2'd1,
        LOCAL_RSP = 2'd2
    } state_e;

    state_e                    state_q;
    logic                      src_q;       // port owning the outstanding transaction
    logic                      rr_prio_q;   // port that wins a tie
    logic                      hold_vld_q;  // forwarded request offered but not yet granted
    logic                      hold_id_q;
    logic                      lock_held_q;
    logic                      lock_id_q;
    logic [ObiCfg.IdWidth-1:0] local_aid_q;

    obi_req_t                  req [2];
    obi_rsp_t                  rsp [2];
    logic [1:0]                is_lock;
    logic [1:0]                elig;
    logic                      any_elig;
    logic                      win_id;
    logic                      win_local;
    logic                      local_hs;
    logic                      fwd_hs;
    logic                      lock_acq;
    logic                      lock_rel;
    logic                      timeout_fire;
    logic [ObiCfg.DataWidth-1:0] lock_status;

    assign req[0]         = sbr0_obi_req_i;
    assign req[1]         = sbr1_obi_req_i;
    assign sbr0_obi_rsp_o = rsp[0];
    assign sbr1_obi_rsp_o = rsp[1];
    assign lock_owner_o   = {lock_held_q, lock_id_q};

    // Eligibility: lock-register accesses always pass; a held lock blocks the non-owner.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            is_lock[i] = (req[i].a.addr[7:0] == LockOffset);
            elig[i]    = req[i].req && (!lock_held_q || (lock_id_q == 1'(i)) || is_lock[i]);
        end
    end

    // Winner selection: keep an offered-but-ungranted request stable, else round-robin.
    always_comb begin
        any_elig = |elig;
        win_id   = rr_prio_q;
        if (hold_vld_q && elig[hold_id_q]) begin
            win_id = hold_id_q;
        end else if (elig[0] && !elig[1]) begin
            win_id = 1'b0;
        end else if (elig[1] && !elig[0]) begin
            win_id = 1'b1;
        end
        win_local = is_lock[win_id];
    end

    // Request path toward the accelerator and handshake detection.
    always_comb begin
        mgr_obi_req_o     = '0;
        mgr_obi_req_o.a   = req[win_id].a;
        if (state_q == IDLE && any_elig && !win_local) begin
            mgr_obi_req_o.req = 1'b1;
        end
        fwd_hs   = mgr_obi_req_o.req && mgr_obi_rsp_i.gnt;
        local_hs = (state_q == IDLE) && any_elig && win_local;
        lock_acq = local_hs && req[win_id].a.we && req[win_id].a.wdata[0] &&
                   (!lock_held_q || (lock_id_q == win_id));
        lock_rel = local_hs && req[win_id].a.we && !req[win_id].a.wdata[0] &&
                   lock_held_q && (lock_id_q == win_id);
        lock_status      = '0;
        lock_status[1:0] = {lock_held_q, lock_id_q};
    end

    // Response routing: gnt to the winner in IDLE, rvalid/r to the source afterwards.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rsp[i] = '0;
            case (state_q)
                IDLE: begin
                    if (any_elig && (win_id == 1'(i))) begin
                        rsp[i].gnt = win_local ? 1'b1 : mgr_obi_rsp_i.gnt;
                    end
                end
                FWD_WAIT: begin
                    if (src_q == 1'(i)) begin
                        rsp[i].rvalid = mgr_obi_rsp_i.rvalid;
                        rsp[i].r      = mgr_obi_rsp_i.r;
                    end
                end
                LOCAL_RSP: begin
                    if (src_q == 1'(i)) begin
                        rsp[i].rvalid  = 1'b1;
                        rsp[i].r.rdata = lock_status;
                        rsp[i].r.rid   = local_aid_q;
                        rsp[i].r.err   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Transaction FSM with round-robin pointer, advanced only on a granted handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            src_q       <= 1'b0;
            rr_prio_q   <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_id_q   <= 1'b0;
            local_aid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (local_hs || fwd_hs) begin
                        state_q    <= local_hs ? LOCAL_RSP : FWD_WAIT;
                        src_q      <= win_id;
                        rr_prio_q  <= ~win_id;
                        hold_vld_q <= 1'b0;
                        if (local_hs) begin
                            local_aid_q <= req[win_id].a.aid;
                        end
                    end else begin
                        hold_vld_q <= mgr_obi_req_o.req;
                        hold_id_q  <= win_id;
                    end
                end
                FWD_WAIT: begin
                    if (mgr_obi_rsp_i.rvalid) begin
                        state_q <= IDLE;
                    end
                end
                LOCAL_RSP: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // Lock register: acquire beats a same-cycle forced release; owner ID clears with the lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_held_q <= 1'b0;
            lock_id_q   <= 1'b0;
        end else if (lock_acq) begin
            lock_held_q <= 1'b1;
            lock_id_q   <= win_id;
        end else if (lock_rel || timeout_fire) begin
            lock_held_q <= 1'b0;
            lock_id_q   <= 1'b0;
        end
    end

`ifdef MAC_ARB_LOCK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(LockTimeout);

    logic [CntW-1:0] idle_cnt_q;
    logic            owner_hs;
    logic            timeout_q;

    assign owner_hs       = lock_held_q && (local_hs || fwd_hs) && (win_id == lock_id_q);
    assign timeout_fire   = lock_held_q && !owner_hs && (idle_cnt_q == CntW'(LockTimeout - 1));
    assign lock_timeout_o = timeout_q;

    // Watchdog: count owner-idle cycles while locked, restart on any owner handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if (!lock_held_q || owner_hs || timeout_fire) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end
`else
    assign timeout_fire   = 1'b0;
    assign lock_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mac_accel_arbiter.sv
// Purpose : directed self-checking bench for mac_accel_arbiter with a small accelerator model.
// Latency : model answers rdata = 0xD0000000 | addr, acc_lat cycles after its handshake.
// Backpress: model always grants; requests are driven just after the rising edge.

module tb_mac_accel_arbiter;
    import mac_arb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    sbr_obi_req_t s0, s1, mreq;
    sbr_obi_rsp_t r0, r1, mrsp;
    logic [1:0]   lock_owner;
    logic         lock_to;

    logic         acc_gnt;
    int           acc_lat;
    logic         acc_pend;
    int           acc_wait;
    logic [31:0]  acc_data;
    logic [0:0]   acc_rid;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_accel_arbiter #(.LockTimeout(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sbr0_obi_req_i (s0),
        .sbr0_obi_rsp_o (r0),
        .sbr1_obi_req_i (s1),
        .sbr1_obi_rsp_o (r1),
        .mgr_obi_req_o  (mreq),
        .mgr_obi_rsp_i  (mrsp),
        .lock_owner_o   (lock_owner),
        .lock_timeout_o (lock_to)
    );

    // Accelerator model: one outstanding transaction, fixed latency, reset discards it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_pend <= 1'b0;
            acc_wait <= 0;
            acc_data <= '0;
            acc_rid  <= '0;
        end else if (mreq.req && acc_gnt) begin
            acc_pend <= 1'b1;
            acc_wait <= acc_lat - 1;
            acc_data <= 32'hD000_0000 | mreq.a.addr;
            acc_rid  <= mreq.a.aid;
        end else if (acc_pend && acc_wait == 0) begin
            acc_pend <= 1'b0;
        end else if (acc_pend) begin
            acc_wait <= acc_wait - 1;
        end
    end

    always_comb begin
        mrsp         = '0;
        mrsp.gnt     = acc_gnt;
        mrsp.rvalid  = acc_pend && (acc_wait == 0);
        mrsp.r.rdata = acc_data;
        mrsp.r.rid   = acc_rid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic rq, input logic [31:0] addr,
                         input logic we, input logic [31:0] wd);
        sbr_obi_req_t t;
        t         = '0;
        t.req     = rq;
        t.a.addr  = addr;
        t.a.we    = we;
        t.a.be    = 4'hF;
        t.a.wdata = wd;
        t.a.aid   = port[0:0];
        if (port == 0) s0 = t;
        else           s1 = t;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt0"},    r0.gnt,     1'b0);
        chk({tag, "_gnt1"},    r1.gnt,     1'b0);
        chk({tag, "_rvalid0"}, r0.rvalid,  1'b0);
        chk({tag, "_rvalid1"}, r1.rvalid,  1'b0);
        chk({tag, "_mgr_req"}, mreq.req,   1'b0);
        chk({tag, "_owner"},   lock_owner, 2'b00);
        chk({tag, "_timeout"}, lock_to,    1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int waited;
        int pulses;
        int at;
        int bad;
        s0 = '0; s1 = '0; acc_gnt = 1'b1; acc_lat = 1; rst_n = 1'b0;
        #2;
        chk_reset_outputs("rst");
        step();
        rst_n = 1'b1;

        // Both ports request from reset: port 0 first, then port 1, no cross-routing.
        drive(0, 1, 32'h10, 0, 0); drive(1, 1, 32'h20, 0, 0); #1;
        chk("rr_gnt0", r0.gnt, 1'b1);
        chk("rr_gnt1_blocked", r1.gnt, 1'b0);
        chk("rr_mgr_req", mreq.req, 1'b1);
        chk("rr_mgr_addr0", mreq.a.addr, 32'h10);
        step(); s0.req = 1'b0; #1;
        chk("rr_rvalid0", r0.rvalid, 1'b1);
        chk("rr_rdata0", r0.r.rdata, 32'hD000_0010);
        chk("rr_rid0", r0.r.rid, 1'b0);
        chk("rr_no_cross1", r1.rvalid, 1'b0);
        chk("rr_wait_gnt1", r1.gnt, 1'b0);
        step(); #1;
        chk("rr_gnt1", r1.gnt, 1'b1);
        chk("rr_mgr_addr1", mreq.a.addr, 32'h20);
        step(); s1.req = 1'b0; #1;
        chk("rr_rvalid1", r1.rvalid, 1'b1);
        chk("rr_rdata1", r1.r.rdata, 32'hD000_0020);
        chk("rr_rid1", r1.r.rid, 1'b1);
        chk("rr_no_cross0", r0.rvalid, 1'b0);

        // Port 1 acquires the lock; port 0 stalls while port 1 keeps going.
        step(); drive(1, 1, 32'hFC, 1, 1); #1;
        chk("acq1_gnt", r1.gnt, 1'b1);
        chk("acq1_not_fwd", mreq.req, 1'b0);
        step(); s1.req = 1'b0; drive(0, 1, 32'h00, 0, 0); #1;
        chk("acq1_rvalid", r1.rvalid, 1'b1);
        chk("acq1_rdata", r1.r.rdata, 32'h3);
        chk("acq1_err", r1.r.err, 1'b0);
        chk("acq1_owner", lock_owner, 2'b11);
        chk("acq1_localrsp_gnt0", r0.gnt, 1'b0);
        step(); drive(1, 1, 32'h30, 0, 0); #1;
        chk("lock_stall0", r0.gnt, 1'b0);
        chk("lock_owner_gnt1", r1.gnt, 1'b1);
        chk("lock_mgr_addr", mreq.a.addr, 32'h30);
        step(); s1.req = 1'b0; #1;
        chk("lock_rdata1", r1.r.rdata, 32'hD000_0030);
        chk("lock_rvalid1", r1.rvalid, 1'b1);
        step(); #1;
        chk("lock_stall0_again", r0.gnt, 1'b0);
        chk("lock_stall_no_mgr", mreq.req, 1'b0);

        // Port 0 tries to steal the lock: not an error, owner unchanged.
        drive(0, 1, 32'hFC, 1, 1); #1;
        chk("steal_gnt0", r0.gnt, 1'b1);
        step(); drive(0, 1, 32'hFC, 0, 0); #1;
        chk("steal_rvalid", r0.rvalid, 1'b1);
        chk("steal_rdata", r0.r.rdata, 32'h3);
        chk("steal_err", r0.r.err, 1'b0);
        chk("steal_owner", lock_owner, 2'b11);
        step(); #1;
        chk("rd_lock_gnt0", r0.gnt, 1'b1);
        step(); drive(0, 1, 32'h00, 0, 0); #1;
        chk("rd_lock_rvalid", r0.rvalid, 1'b1);
        chk("rd_lock_rdata", r0.r.rdata, 32'h3);

        // Port 1 releases; port 0 is granted in the cycle after the release response.
        step(); drive(1, 1, 32'hFC, 1, 0); #1;
        chk("rel_gnt1", r1.gnt, 1'b1);
        chk("rel_stall0", r0.gnt, 1'b0);
        step(); s1.req = 1'b0; #1;
        chk("rel_rdata", r1.r.rdata, 32'h0);
        chk("rel_owner", lock_owner, 2'b00);
        acc_lat = 5;
        step(); #1;
        chk("rel_gnt0", r0.gnt, 1'b1);
        chk("rel_mgr_addr", mreq.a.addr, 32'h00);

        // Slow accelerator: no second grant until rvalid, response on the right port.
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) begin
                s0.req = 1'b0;
                drive(1, 1, 32'h40, 0, 0);
            end
            #1;
            if (i < 5) begin
                chk("slow_no_rvalid", r0.rvalid, 1'b0);
                chk("slow_no_gnt1", r1.gnt, 1'b0);
            end else begin
                chk("slow_rvalid0", r0.rvalid, 1'b1);
                chk("slow_rdata0", r0.r.rdata, 32'hD000_0000);
                chk("slow_gnt1_same_cycle", r1.gnt, 1'b0);
                chk("slow_no_cross1", r1.rvalid, 1'b0);
            end
        end
        step(); #1;
        chk("slow_gnt1", r1.gnt, 1'b1);
        chk("slow_mgr_addr1", mreq.a.addr, 32'h40);
        waited = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) s1.req = 1'b0;
            #1;
            if (r1.rvalid) begin
                waited = i;
                break;
            end
        end
        chk("slow_latency1", waited, 5);
        chk("slow_rdata1", r1.r.rdata, 32'hD000_0040);
        acc_lat = 1;

        // Port 0 takes the lock and idles.
        step(); drive(0, 1, 32'hFC, 1, 1); #1;
        chk("idle_acq_gnt", r0.gnt, 1'b1);
        step(); s0.req = 1'b0; #1;
        chk("idle_acq_rdata", r0.r.rdata, 32'h2);
        chk("idle_acq_owner", lock_owner, 2'b10);
`ifdef MAC_ARB_LOCK_TIMEOUT_EN
        pulses = 0; at = 0;
        for (int k = 2; k <= 40; k++) begin
            step(); #1;
            if (lock_to) begin
                pulses++;
                if (at == 0) at = k;
            end
        end
        chk("to_pulse_cycle", at, 17);
        chk("to_pulse_count", pulses, 1);
        chk("to_owner_cleared", lock_owner, 2'b00);
`else
        pulses = 0; bad = 0;
        for (int k = 1; k <= 1000; k++) begin
            step(); #1;
            if (lock_to) pulses++;
            if (lock_owner !== 2'b10) bad++;
        end
        chk("persist_no_pulse", pulses, 0);
        chk("persist_owner_cycles", bad, 0);
        chk("persist_owner", lock_owner, 2'b10);
`endif

        // Reset during FWD_WAIT with the lock held.
        step(); drive(0, 1, 32'hFC, 1, 1); #1;
        chk("mrst_acq_gnt", r0.gnt, 1'b1);
        step(); s0.req = 1'b0; #1;
        chk("mrst_owner", lock_owner, 2'b10);
        acc_lat = 5;
        step(); drive(0, 1, 32'h50, 0, 0); #1;
        chk("mrst_fwd_gnt", r0.gnt, 1'b1);
        step(); s0.req = 1'b0; #1;
        chk("mrst_waiting", r0.rvalid, 1'b0);
        rst_n = 1'b0; acc_lat = 1; #1;
        chk_reset_outputs("mrst");
        step(); step();
        rst_n = 1'b1;
        drive(0, 1, 32'h60, 0, 0); drive(1, 1, 32'h70, 0, 0); #1;
        chk("post_rst_gnt0", r0.gnt, 1'b1);
        chk("post_rst_gnt1", r1.gnt, 1'b0);
        chk("post_rst_addr", mreq.a.addr, 32'h60);
        step(); s0.req = 1'b0; s1.req = 1'b0; #1;
        chk("post_rst_rvalid", r0.rvalid, 1'b1);
        chk("post_rst_rdata", r0.r.rdata, 32'hD000_0060);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
